// File: rtl/rw_pkg.sv
// Shared definitions for the register-writeback stage: load funct3 codes,
// default datapath width and the per-lane control record held in the stage register.
package rw_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   // Data lives beside this record so the record stays independent of XLEN.
   typedef struct packed {
      logic       valid;
      logic       wen;
      logic [4:0] dst;
   } lane_result_t;

endpackage

// File: rtl/rw_if.sv
// Memory-access to writeback bundle: one flattened field per lane for each signal,
// with lane 0 being the oldest instruction in program order.
interface rw_if #(
   parameter int LANES = 2,
   parameter int XLEN  = rw_pkg::XLEN_DEF
);
   logic [LANES-1:0]      validMA;
   logic [LANES-1:0]      is_loadMA;
   logic [3*LANES-1:0]    load_funct3MA;
   logic [2*LANES-1:0]    addr_lsbMA;
   logic [XLEN*LANES-1:0] aluresultMA;
   logic [XLEN*LANES-1:0] load_reg_valueMA;
   logic [5*LANES-1:0]    dstregMA;
   logic [LANES-1:0]      reg_weMA;

   modport master (
      output validMA, is_loadMA, load_funct3MA, addr_lsbMA,
             aluresultMA, load_reg_valueMA, dstregMA, reg_weMA
   );

   modport slave (
      input  validMA, is_loadMA, load_funct3MA, addr_lsbMA,
             aluresultMA, load_reg_valueMA, dstregMA, reg_weMA
   );
endinterface

// File: rtl/load_align.sv
// Combinational load formatter: extracts a byte or halfword from an aligned memory
// word and sign- or zero-extends it; unknown funct3 codes fall back to a full word.
module load_align
   import rw_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [2:0]      funct3,
   input  logic [1:0]      addr_lsb,
   input  logic [XLEN-1:0] word,
   output logic [XLEN-1:0] data
);
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // NOTE: every output of an always_comb is assigned on every path (default
   // branches below), otherwise synthesis infers a latch.
   always_comb begin
      case (addr_lsb)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase

      // Bit 0 of the offset is deliberately ignored for halves.
      half_sel = addr_lsb[1] ? word[31:16] : word[15:0];

      case (funct3)
         LB:      data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         LH:      data = {{(XLEN-16){half_sel[15]}}, half_sel};
         LBU:     data = {{(XLEN-8){1'b0}}, byte_sel};
         LHU:     data = {{(XLEN-16){1'b0}}, half_sel};
         default: data = word;
      endcase
   end
endmodule

// File: rtl/rw_stage.sv
// Register-writeback stage: formats per-lane results, resolves same-register write
// conflicts in favour of the youngest lane, registers the bundle and counts retirements.
module rw_stage
   import rw_pkg::*;
#(
   parameter int LANES = 2,
   parameter int XLEN  = XLEN_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  flush,
   rw_if.slave                   ma,
   output logic [XLEN*LANES-1:0] wb_dataRW,
   output logic [5*LANES-1:0]    dstregRW,
   output logic [LANES-1:0]      wb_enRW,
   output logic [63:0]           retire_count
);
   logic [XLEN-1:0] fmt_data [LANES];
   logic [XLEN-1:0] data_q   [LANES];
   lane_result_t    next_res [LANES];
   lane_result_t    res_q    [LANES];
   logic [LANES-1:0] req;
   logic [63:0]      retire_inc;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic [XLEN-1:0] load_val;

      load_align #(.XLEN(XLEN)) u_align (
         .funct3   (ma.load_funct3MA[3*g +: 3]),
         .addr_lsb (ma.addr_lsbMA[2*g +: 2]),
         .word     (ma.load_reg_valueMA[XLEN*g +: XLEN]),
         .data     (load_val)
      );

      assign fmt_data[g] = ma.is_loadMA[g] ? load_val : ma.aluresultMA[XLEN*g +: XLEN];

      assign wb_dataRW[XLEN*g +: XLEN] = data_q[g];
      assign dstregRW[5*g +: 5]        = res_q[g].dst;
      assign wb_enRW[g]                = res_q[g].valid & res_q[g].wen;
   end

   // A lane keeps its write only if no younger lane writes the same register.
   always_comb begin
      retire_inc = '0;
      for (int i = 0; i < LANES; i++) begin
         req[i] = ma.validMA[i] & ma.reg_weMA[i] & (ma.dstregMA[5*i +: 5] != 5'd0);
         retire_inc = retire_inc + 64'(ma.validMA[i]);
      end
      for (int i = 0; i < LANES; i++) begin
         next_res[i].valid = ma.validMA[i];
         next_res[i].dst   = ma.dstregMA[5*i +: 5];
         next_res[i].wen   = req[i];
         for (int j = i + 1; j < LANES; j++) begin
            if (req[j] && (ma.dstregMA[5*j +: 5] == ma.dstregMA[5*i +: 5]))
               next_res[i].wen = 1'b0;
         end
      end
   end

   // NOTE: state is updated with nonblocking assignments so every register samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LANES; i++) begin
            res_q[i]  <= '0;
            data_q[i] <= '0;
         end
         retire_count <= '0;
      end else if (flush) begin
         for (int i = 0; i < LANES; i++) begin
            res_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else if (!stall) begin
         for (int i = 0; i < LANES; i++) begin
            res_q[i]  <= next_res[i];
            data_q[i] <= fmt_data[i];
         end
         retire_count <= retire_count + retire_inc;
      end else begin
         // Held bundle: contents stay, but the regfile must not be written twice.
         for (int i = 0; i < LANES; i++)
            res_q[i].wen <= 1'b0;
      end
   end
endmodule

// File: doc/rw_stage.md
RW_STAGE -- requirements
Module: rw_stage

Interface
REQ-001 Parameter LANES, default 2, number of writeback lanes (1..4); lane 0 is oldest in program order.
REQ-002 Parameter XLEN, default 32, datapath width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 stall  input  1  downstream hold; stage register keeps contents.
REQ-006 flush  input  1  discard incoming bundle.
REQ-007 validMA  input  LANES  per-lane instruction valid.
REQ-008 is_loadMA  input  LANES  lane result comes from memory.
REQ-009 load_funct3MA  input  3*LANES  per-lane load type.
REQ-010 addr_lsbMA  input  2*LANES  per-lane load byte offset.
REQ-011 aluresultMA  input  XLEN*LANES  per-lane ALU result.
REQ-012 load_reg_valueMA  input  XLEN*LANES  per-lane raw aligned memory word.
REQ-013 dstregMA  input  5*LANES  per-lane destination register.
REQ-014 reg_weMA  input  LANES  per-lane register write request.
REQ-015 wb_dataRW  output  XLEN*LANES  per-lane writeback data.
REQ-016 dstregRW  output  5*LANES  per-lane destination register.
REQ-017 wb_enRW  output  LANES  per-lane regfile write strobe.
REQ-018 retire_count  output  64  count of retired instructions.

Function
REQ-019 The stage SHALL register all lane results, giving exactly 1 cycle latency from MA inputs to RW outputs.
REQ-020 When stall=0 and flush=0, the stage SHALL capture the bundle on the rising edge.
REQ-021 When flush=1, the stage SHALL capture an all-invalid bundle regardless of stall (flush has priority).
REQ-022 When stall=1 and flush=0, registered data, dstreg and valid SHALL hold.
REQ-023 wb_enRW SHALL be asserted only in the first cycle after capture; it SHALL be 0 in later held cycles, so each bundle writes the regfile exactly once.
REQ-024 Per lane, wb_data SHALL be the formatted load value if is_load=1, otherwise aluresult.
REQ-025 Load formatting SHALL be: 000 LB sign-extended byte at addr_lsb; 001 LH sign-extended half at addr_lsb[1]; 010 LW full word; 100 LBU zero-extended byte; 101 LHU zero-extended half; any other code treated as LW.
REQ-026 Half loads SHALL ignore addr_lsb[0] (misalignment is handled upstream).
REQ-027 A lane write SHALL be enabled only if valid=1, reg_we=1 and dstreg!=0.
REQ-028 If two or more enabled lanes target the same dstreg, only the highest-index (youngest) lane SHALL keep its write enable.
REQ-029 On each capture, retire_count SHALL increase by the popcount of captured valid lanes, whether or not they write a register.
REQ-030 retire_count SHALL wrap modulo 2^64.
REQ-031 Held cycles and flushed captures SHALL NOT change retire_count.

Reset
REQ-032 While rst=1, all lane valid bits SHALL be 0, and wb_enRW, wb_dataRW, dstregRW and retire_count SHALL be 0.
REQ-033 Asserting rst mid-bundle SHALL drop that bundle with no regfile write.
REQ-034 The first capture after deassertion SHALL behave as a normal capture.

Structure
REQ-035 A shared package rw_pkg SHALL hold the load funct3 constants (LB, LH, LW, LBU, LHU), the XLEN default, and the lane-result struct typedef.
REQ-036 Load formatting SHALL be a combinational sub-module load_align, instantiated once per lane.
REQ-037 Conflict resolution, the stage register and the retire counter SHALL reside in rw_stage.

Verification
REQ-038 LB test: lane0 is_load, funct3=000, addr_lsb=3, word 0x80FF_1234 -> next cycle wb_data=0xFFFF_FF80, wb_en=1.
REQ-039 Conflict test: both lanes valid, reg_we=1, dstreg=5 -> wb_enRW=2'b10 and lane1 data written.
REQ-040 x0 and invalid lanes: lane0 dst=0, lane1 valid=0 -> wb_enRW=00; retire_count +1.
REQ-041 Stall test: capture a bundle, then stall=1 for 3 cycles -> wb_en high 1 cycle only, data held, retire_count incremented once.
REQ-042 Flush+stall test: flush=1 and stall=1 with a valid bundle -> no write, retire_count unchanged.
REQ-043 Reset test: async rst pulse between clock edges -> outputs 0 immediately; retire_count 0.
